// File: rtl/gpio_ctrl_if.sv
// rtl/gpio_ctrl_if.sv - bus-side access signals between the bus interface unit and gpio_ctrl
interface gpio_ctrl_if;
  logic        gpio_en_i;
  logic        mem_we_i;
  logic [3:0]  mem_be_i;
  logic [31:0] mem_addr_i;
  logic [31:0] wmem_data_i;
  logic [31:0] gpio_data_o;

  modport master (
    output gpio_en_i,
    output mem_we_i,
    output mem_be_i,
    output mem_addr_i,
    output wmem_data_i,
    input  gpio_data_o
  );

  modport slave (
    input  gpio_en_i,
    input  mem_we_i,
    input  mem_be_i,
    input  mem_addr_i,
    input  wmem_data_i,
    output gpio_data_o
  );
endinterface

// File: rtl/gpio_ctrl.sv
// rtl/gpio_ctrl.sv - GPIO register block: output/direction registers, synchronised inputs, rising-edge interrupt
module gpio_ctrl #(
  parameter int GPIO_W      = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  gpio_ctrl_if.slave        bus,
  input  logic [GPIO_W-1:0] gpio_in_i,
  output logic [GPIO_W-1:0] gpio_out_o,
  output logic [GPIO_W-1:0] gpio_oe_o,
  output logic              irq_o
);

  localparam logic [2:0] IDX_DATA_IN  = 3'd0;
  localparam logic [2:0] IDX_DATA_OUT = 3'd1;
  localparam logic [2:0] IDX_DIR      = 3'd2;
  localparam logic [2:0] IDX_IRQ_EN   = 3'd3;
  localparam logic [2:0] IDX_IRQ_FLAG = 3'd4;

  logic [GPIO_W-1:0] data_out_q;
  logic [GPIO_W-1:0] dir_q;
  logic [GPIO_W-1:0] irq_en_q;
  logic [GPIO_W-1:0] irq_flag_q;
  logic [GPIO_W-1:0] prev_q;
  logic [GPIO_W-1:0] sync_q [SYNC_STAGES];
  logic [GPIO_W-1:0] sync;
  logic [GPIO_W-1:0] rise;
  logic [GPIO_W-1:0] w1c_mask;
  logic [GPIO_W-1:0] wr_masked;
  logic [31:0]       byte_mask;
  logic [31:0]       rd_mux;
  logic [31:0]       wr_full;
  logic [2:0]        idx;
  logic              wr_en;
  logic              rd_en;
  logic              unused_addr_bits;

  // Merge write data into an existing register value under the byte strobes.
  function automatic logic [GPIO_W-1:0] merge_bytes(
    input logic [GPIO_W-1:0] old_val,
    input logic [31:0]       wdata,
    input logic [31:0]       mask
  );
    logic [31:0] full;
    full = '0;
    full[GPIO_W-1:0] = old_val;
    full = (full & ~mask) | (wdata & mask);
    return full[GPIO_W-1:0];
  endfunction

  assign idx              = bus.mem_addr_i[4:2];
  assign wr_en            = bus.gpio_en_i & bus.mem_we_i;
  assign rd_en            = bus.gpio_en_i & ~bus.mem_we_i;
  assign unused_addr_bits = ^{bus.mem_addr_i[31:5], bus.mem_addr_i[1:0]};

  assign byte_mask = {{8{bus.mem_be_i[3]}}, {8{bus.mem_be_i[2]}},
                      {8{bus.mem_be_i[1]}}, {8{bus.mem_be_i[0]}}};

  assign sync = sync_q[SYNC_STAGES-1];
  assign rise = sync & ~prev_q;

  always_comb begin
    wr_full   = bus.wmem_data_i & byte_mask;
    wr_masked = wr_full[GPIO_W-1:0];
    w1c_mask  = (wr_en && idx == IDX_IRQ_FLAG) ? wr_masked : '0;
  end

  // Read mux sees register state before this edge's update, so same-edge writes return old data.
  always_comb begin
    rd_mux = '0;
    case (idx)
      IDX_DATA_IN:  rd_mux[GPIO_W-1:0] = sync;
      IDX_DATA_OUT: rd_mux[GPIO_W-1:0] = data_out_q;
      IDX_DIR:      rd_mux[GPIO_W-1:0] = dir_q;
      IDX_IRQ_EN:   rd_mux[GPIO_W-1:0] = irq_en_q;
      IDX_IRQ_FLAG: rd_mux[GPIO_W-1:0] = irq_flag_q;
      default:      rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= gpio_in_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out_q <= '0;
      dir_q      <= '0;
      irq_en_q   <= '0;
    end else if (wr_en) begin
      case (idx)
        IDX_DATA_OUT: data_out_q <= merge_bytes(data_out_q, bus.wmem_data_i, byte_mask);
        IDX_DIR:      dir_q      <= merge_bytes(dir_q, bus.wmem_data_i, byte_mask);
        IDX_IRQ_EN:   irq_en_q   <= merge_bytes(irq_en_q, bus.wmem_data_i, byte_mask);
        default:      ;
      endcase
    end
  end

  // A new rise on the same edge as a W1C write keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_flag_q <= '0;
    end else begin
      irq_flag_q <= (irq_flag_q & ~w1c_mask) | (rise & irq_en_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.gpio_data_o <= '0;
    end else if (rd_en) begin
      bus.gpio_data_o <= rd_mux;
    end
  end

  assign gpio_out_o = data_out_q;
  assign gpio_oe_o  = dir_q;
  assign irq_o      = |(irq_flag_q & irq_en_q);

endmodule

// File: tb/tb_gpio_ctrl.sv
// tb/tb_gpio_ctrl.sv - scoreboard bench for gpio_ctrl
module tb_gpio_ctrl;
  localparam int GPIO_W = 32;
  localparam int SS     = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [GPIO_W-1:0] gpio_in;
  logic [GPIO_W-1:0] gpio_out;
  logic [GPIO_W-1:0] gpio_oe;
  logic              irq;

  gpio_ctrl_if bus ();

  gpio_ctrl #(.GPIO_W(GPIO_W), .SYNC_STAGES(SS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .gpio_in_i  (gpio_in),
    .gpio_out_o (gpio_out),
    .gpio_oe_o  (gpio_oe),
    .irq_o      (irq)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] sb[$];
  logic [31:0] exp_v;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    bus.gpio_en_i   = 1'b0;
    bus.mem_we_i    = 1'b0;
    bus.mem_be_i    = 4'h0;
    bus.mem_addr_i  = 32'h0;
    bus.wmem_data_i = 32'h0;
  endtask

  task automatic drive_write(input logic [2:0] idx, input logic [31:0] data, input logic [3:0] be);
    bus.gpio_en_i   = 1'b1;
    bus.mem_we_i    = 1'b1;
    bus.mem_be_i    = be;
    bus.mem_addr_i  = 32'h4000_0000 | {27'h0, idx, 2'b11};
    bus.wmem_data_i = data;
  endtask

  task automatic write_reg(input logic [2:0] idx, input logic [31:0] data, input logic [3:0] be);
    drive_write(idx, data, be);
    tick();
    bus_idle();
  endtask

  task automatic drive_read(input logic [2:0] idx, input logic [31:0] expected);
    bus.gpio_en_i   = 1'b1;
    bus.mem_we_i    = 1'b0;
    bus.mem_be_i    = 4'hF;
    bus.mem_addr_i  = 32'h4000_0000 | {27'h0, idx, 2'b00};
    bus.wmem_data_i = 32'h5A5A_5A5A;
    sb.push_back(expected);
  endtask

  task automatic test_reset();
    bus_idle();
    gpio_in = '0;
    rst_n = 1'b0;
    tick();
    n_tests++;
    if ({gpio_out, gpio_oe, irq, bus.gpio_data_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: out=%08h oe=%08h irq=%0b rd=%08h want all 0", gpio_out, gpio_oe, irq, bus.gpio_data_o);
    end
    rst_n = 1'b1;
    tick();
    drive_write(3'd1, 32'hFFFF_FFFF, 4'hF);
    #3 rst_n = 1'b0;
    tick();
    n_tests++;
    if (gpio_out !== '0 || gpio_oe !== '0 || irq !== 1'b0 || bus.gpio_data_o !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mid_write: out=%08h oe=%08h irq=%0b rd=%08h want all 0", gpio_out, gpio_oe, irq, bus.gpio_data_o);
    end
    bus_idle();
    rst_n = 1'b1;
    tick();
    drive_read(3'd1, 32'h0);
    tick();
    bus_idle();
    exp_v = sb.pop_front();
    n_tests++;
    if (bus.gpio_data_o !== exp_v) begin
      n_fail++;
      $display("FAIL reset_rd_data_out: got %08h want %08h", bus.gpio_data_o, exp_v);
    end
  endtask

  task automatic test_dir_out();
    write_reg(3'd2, 32'h0000_00FF, 4'b0001);
    n_tests++;
    if (gpio_oe !== 32'h0000_00FF) begin
      n_fail++;
      $display("FAIL dir_pad: got %08h want 000000ff", gpio_oe);
    end
    write_reg(3'd1, 32'hA5A5_A5A5, 4'b1111);
    n_tests++;
    if (gpio_out !== 32'hA5A5_A5A5) begin
      n_fail++;
      $display("FAIL out_pad: got %08h want a5a5a5a5", gpio_out);
    end
    drive_read(3'd2, 32'h0000_00FF);
    tick();
    bus_idle();
    exp_v = sb.pop_front();
    n_tests++;
    if (bus.gpio_data_o !== exp_v) begin
      n_fail++;
      $display("FAIL rd_dir: got %08h want %08h", bus.gpio_data_o, exp_v);
    end
    drive_read(3'd1, 32'hA5A5_A5A5);
    tick();
    bus_idle();
    exp_v = sb.pop_front();
    n_tests++;
    if (bus.gpio_data_o !== exp_v) begin
      n_fail++;
      $display("FAIL rd_data_out: got %08h want %08h", bus.gpio_data_o, exp_v);
    end
  endtask

  task automatic test_byte_strobes();
    write_reg(3'd1, 32'h1122_3344, 4'hF);
    write_reg(3'd1, 32'hAABB_CCDD, 4'b0110);
    n_tests++;
    if (gpio_out !== 32'h11BB_CC44) begin
      n_fail++;
      $display("FAIL be_pad: got %08h want 11bbcc44", gpio_out);
    end
    write_reg(3'd1, 32'h0000_0000, 4'b0000);
    n_tests++;
    if (gpio_out !== 32'h11BB_CC44) begin
      n_fail++;
      $display("FAIL be_zero_noop: got %08h want 11bbcc44", gpio_out);
    end
    drive_read(3'd1, 32'h11BB_CC44);
    tick();
    bus_idle();
    exp_v = sb.pop_front();
    n_tests++;
    if (bus.gpio_data_o !== exp_v) begin
      n_fail++;
      $display("FAIL be_rd: got %08h want %08h", bus.gpio_data_o, exp_v);
    end
  endtask

  task automatic test_edge_irq();
    write_reg(3'd3, 32'h1, 4'hF);
    gpio_in[0] = 1'b1;
    for (int k = 1; k <= SS + 1; k++) begin
      tick();
      n_tests++;
      if (irq !== (k == SS + 1)) begin
        n_fail++;
        $display("FAIL irq_latency_cycle%0d: got %0b want %0b", k, irq, (k == SS + 1));
      end
    end
    drive_read(3'd4, 32'h1);
    tick();
    bus_idle();
    exp_v = sb.pop_front();
    n_tests++;
    if (bus.gpio_data_o !== exp_v) begin
      n_fail++;
      $display("FAIL irq_flag_set: got %08h want %08h", bus.gpio_data_o, exp_v);
    end
    gpio_in[1] = 1'b1;
    repeat (SS + 2) tick();
    drive_read(3'd4, 32'h1);
    tick();
    drive_read(3'd0, 32'h3);
    exp_v = sb.pop_front();
    n_tests++;
    if (bus.gpio_data_o !== exp_v) begin
      n_fail++;
      $display("FAIL irq_pin1_masked: got %08h want %08h", bus.gpio_data_o, exp_v);
    end
    tick();
    bus_idle();
    exp_v = sb.pop_front();
    n_tests++;
    if (bus.gpio_data_o !== exp_v) begin
      n_fail++;
      $display("FAIL rd_data_in: got %08h want %08h", bus.gpio_data_o, exp_v);
    end
  endtask

  task automatic test_w1c_race();
    gpio_in[0] = 1'b0;
    repeat (SS + 1) tick();
    gpio_in[0] = 1'b1;
    repeat (SS) tick();
    write_reg(3'd4, 32'h1, 4'hF);
    n_tests++;
    if (irq !== 1'b1) begin
      n_fail++;
      $display("FAIL w1c_race_irq: got %0b want 1", irq);
    end
    write_reg(3'd3, 32'h0, 4'hF);
    n_tests++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_en_mask: got %0b want 0", irq);
    end
    drive_read(3'd4, 32'h1);
    tick();
    bus_idle();
    exp_v = sb.pop_front();
    n_tests++;
    if (bus.gpio_data_o !== exp_v) begin
      n_fail++;
      $display("FAIL flag_kept_after_en_clear: got %08h want %08h", bus.gpio_data_o, exp_v);
    end
    write_reg(3'd3, 32'h1, 4'hF);
    n_tests++;
    if (irq !== 1'b1) begin
      n_fail++;
      $display("FAIL irq_reenable: got %0b want 1", irq);
    end
    write_reg(3'd4, 32'h1, 4'hF);
    n_tests++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL w1c_clear_irq: got %0b want 0", irq);
    end
    drive_read(3'd4, 32'h0);
    tick();
    bus_idle();
    exp_v = sb.pop_front();
    n_tests++;
    if (bus.gpio_data_o !== exp_v) begin
      n_fail++;
      $display("FAIL w1c_clear_rd: got %08h want %08h", bus.gpio_data_o, exp_v);
    end
  endtask

  task automatic test_back_to_back();
    write_reg(3'd0, 32'hDEAD_BEEF, 4'hF);
    write_reg(3'd6, 32'hDEAD_BEEF, 4'hF);
    n_tests++;
    if (gpio_out !== 32'h11BB_CC44 || gpio_oe !== 32'hFF || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL ro_reserved_write: out=%08h oe=%08h irq=%0b want 11bbcc44 000000ff 0", gpio_out, gpio_oe, irq);
    end
    drive_read(3'd0, 32'h3);
    tick();
    drive_read(3'd6, 32'h0);
    exp_v = sb.pop_front();
    n_tests++;
    if (bus.gpio_data_o !== exp_v) begin
      n_fail++;
      $display("FAIL rd_idx0: got %08h want %08h", bus.gpio_data_o, exp_v);
    end
    tick();
    drive_read(3'd1, 32'h11BB_CC44);
    exp_v = sb.pop_front();
    n_tests++;
    if (bus.gpio_data_o !== exp_v) begin
      n_fail++;
      $display("FAIL rd_idx6: got %08h want %08h", bus.gpio_data_o, exp_v);
    end
    tick();
    drive_read(3'd2, 32'h0000_00FF);
    exp_v = sb.pop_front();
    n_tests++;
    if (bus.gpio_data_o !== exp_v) begin
      n_fail++;
      $display("FAIL b2b_rd1: got %08h want %08h", bus.gpio_data_o, exp_v);
    end
    tick();
    drive_read(3'd3, 32'h1);
    exp_v = sb.pop_front();
    n_tests++;
    if (bus.gpio_data_o !== exp_v) begin
      n_fail++;
      $display("FAIL b2b_rd2: got %08h want %08h", bus.gpio_data_o, exp_v);
    end
    tick();
    bus_idle();
    exp_v = sb.pop_front();
    n_tests++;
    if (bus.gpio_data_o !== exp_v) begin
      n_fail++;
      $display("FAIL b2b_rd3: got %08h want %08h", bus.gpio_data_o, exp_v);
    end
    tick();
    write_reg(3'd1, 32'h0F0F_0F0F, 4'hF);
    n_tests++;
    if (bus.gpio_data_o !== exp_v) begin
      n_fail++;
      $display("FAIL rd_hold: got %08h want %08h", bus.gpio_data_o, exp_v);
    end
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d entries want 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_dir_out();
    test_byte_strobes();
    test_edge_irq();
    test_w1c_race();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
